// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16-style fetch controller: FSM states,
// opcode/instruction constants and branch condition codes.
package cr16_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0]  OPC_BCOND  = 4'hC;
    localparam logic [15:0] INSTR_HALT = 16'hFFFF;

    // Sequential fetch advances the PC by one word.
    localparam logic [7:0]  PC_INC_SEQ = 8'h01;

    // Branch condition codes carried in instr[11:8].
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator: maps a 4-bit condition code
// and the processor status flags to a take/no-take decision.
module cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_f,
    input  logic       flag_l,
    input  logic       flag_n,
    output logic       take
);

    // Decode the condition against the current flags.
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take =  flag_z;
            COND_NE: take = ~flag_z;
            COND_CS: take =  flag_c;
            COND_CC: take = ~flag_c;
            COND_HI: take =  flag_l;
            COND_LS: take = ~flag_l;
            COND_GT: take =  flag_n;
            COND_LE: take = ~flag_n;
            COND_FS: take =  flag_f;
            COND_FC: take = ~flag_f;
            COND_LO: take = ~flag_l & ~flag_z;
            COND_HS: take =  flag_l |  flag_z;
            COND_LT: take = ~flag_n & ~flag_z;
            COND_GE: take =  flag_n |  flag_z;
            COND_UC: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequences FETCH -> WAIT -> DECODE -> UPDATE,
// latches the instruction, stalls on exec_busy, resolves conditional
// branches into a signed PC displacement and parks in HALT on 16'hFFFF.
module fetch_controller
    import cr16_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] instr_data,
    input  logic        exec_busy,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        flag_f,
    input  logic        flag_l,
    input  logic        flag_n,
    output logic        pc_enable,
    output logic [7:0]  pc_increase,
    output logic [15:0] instr_reg,
    output logic        instr_valid,
    output logic        halted
);

    state_t      r_state;
    logic        r_pc_enable;
    logic [7:0]  r_pc_increase;
    logic [15:0] r_instr_reg;
    logic        r_instr_valid;
    logic        r_halted;

    logic        w_take;
    logic        w_is_bcond;
    logic        w_is_halt;
    logic [7:0]  w_next_inc;

    // Flags are fed straight in, so they are sampled on the same cycle
    // the controller leaves DECODE.
    cond_eval u_cond_eval (
        .cond   (r_instr_reg[11:8]),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_f (flag_f),
        .flag_l (flag_l),
        .flag_n (flag_n),
        .take   (w_take)
    );

    assign w_is_bcond = (r_instr_reg[15:12] == OPC_BCOND);
    assign w_is_halt  = (r_instr_reg == INSTR_HALT);
    assign w_next_inc = (w_is_bcond && w_take) ? r_instr_reg[7:0] : PC_INC_SEQ;

    // Main FSM; every output is registered and reflects the current state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= S_FETCH;
            r_pc_enable   <= 1'b0;
            r_pc_increase <= 8'h00;
            r_instr_reg   <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                // Address already presented; wait out the memory latency.
                S_FETCH: begin
                    r_pc_enable <= 1'b0;
                    r_state     <= S_WAIT;
                end
                // Read data is valid now; capture it for decode.
                S_WAIT: begin
                    r_instr_reg   <= instr_data;
                    r_instr_valid <= 1'b1;
                    r_state       <= S_DECODE;
                end
                // Hold the instruction until the datapath accepts it.
                S_DECODE: begin
                    if (!exec_busy) begin
                        r_instr_valid <= 1'b0;
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_pc_enable   <= 1'b1;
                            r_pc_increase <= w_next_inc;
                            r_state       <= S_UPDATE;
                        end
                    end
                end
                // Single-cycle PC update pulse; displacement stays put after.
                S_UPDATE: begin
                    r_pc_enable <= 1'b0;
                    r_state     <= S_FETCH;
                end
                // Only Reset leaves this state.
                S_HALT: begin
                    r_pc_enable   <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
                default: begin
                    r_pc_enable   <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= S_FETCH;
                end
            endcase
        end
    end

    assign pc_enable   = r_pc_enable;
    assign pc_increase = r_pc_increase;
    assign instr_reg   = r_instr_reg;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have one clock, Clock; reset is synchronous and active-high, named Reset.
REQ-002 Clock  input  1  rising-edge system clock.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 instr_data  input  16  instruction memory read data, valid one cycle after the PC address changes.
REQ-005 exec_busy  input  1  high = datapath not ready to accept the decoded instruction.
REQ-006 flag_z, flag_c, flag_f, flag_l, flag_n  input  1 each  processor status flags.
REQ-007 pc_enable  output  1  one-cycle pulse; the program counter adds pc_increase on this cycle.
REQ-008 pc_increase  output  8  signed PC displacement (two's complement).
REQ-009 instr_reg  output  16  latched current instruction.
REQ-010 instr_valid  output  1  instr_reg is valid for the datapath.
REQ-011 halted  output  1  the controller is in the halt state.

Function
REQ-012 The controller SHALL implement the states S_FETCH, S_WAIT, S_DECODE, S_UPDATE and S_HALT, all with registered outputs.
REQ-013 S_FETCH SHALL go to S_WAIT unconditionally, which allows for the 1-cycle memory latency.
REQ-014 S_WAIT SHALL latch instr_data into instr_reg and go to S_DECODE.
REQ-015 In S_DECODE, instr_valid SHALL be 1; while exec_busy=1 the controller SHALL hold S_DECODE with instr_reg unchanged.
REQ-016 When S_DECODE is left (exec_busy=0), the flags SHALL be sampled on that same cycle.
REQ-017 If instr_reg=16'hFFFF on leaving S_DECODE, the next state SHALL be S_HALT with pc_enable=0.
REQ-018 If instr_reg[15:12]=4'hC (Bcond) and the condition instr_reg[11:8] is true, pc_increase SHALL be instr_reg[7:0]; otherwise pc_increase SHALL be 8'sd1. The next state SHALL be S_UPDATE.
REQ-019 Conditions SHALL be decoded as follows:
- 0 EQ Z
- 1 NE !Z
- 2 CS C
- 3 CC !C
- 4 HI L
- 5 LS !L
- 6 GT N
- 7 LE !N
- 8 FS F
- 9 FC !F
- A LO !L&!Z
- B HS L|Z
- C LT !N&!Z
- D GE N|Z
- E always
- F never
REQ-020 In S_UPDATE, pc_enable SHALL be 1 for exactly one cycle, pc_increase SHALL be stable and instr_valid SHALL be 0; the next state SHALL be S_FETCH.
REQ-021 pc_enable SHALL be 0 in every state other than S_UPDATE; pc_increase SHALL hold its last value outside S_UPDATE.
REQ-022 An unstalled instruction SHALL take exactly 4 cycles (FETCH, WAIT, DECODE, UPDATE).
REQ-023 A displacement of 0 is legal (self-loop); 8'h80 SHALL produce -128. Address wrap-around is the program counter's concern, not this block's.
REQ-024 S_HALT SHALL set halted=1, pc_enable=0 and instr_valid=0, and SHALL be exited only by Reset.
REQ-025 exec_busy SHALL be ignored in every state except S_DECODE.

Reset
REQ-026 Reset=1 at a rising edge SHALL force state=S_FETCH, pc_enable=0, pc_increase=0, instr_reg=0, instr_valid=0 and halted=0, from any state including mid-stall and S_HALT.
REQ-027 Reset SHALL take priority over every other input on the same edge.

Structure
REQ-028 The state encodings, OPC_BCOND=4'hC, INSTR_HALT=16'hFFFF and the condition codes SHALL reside in a shared package, cr16_pkg.
REQ-029 Condition evaluation SHALL be a combinational sub-module, cond_eval (inputs: cond[3:0] and the five flags; output: take).

Verification
REQ-030 Reset, then instr_data=16'h0000 with exec_busy=0 -> pc_enable pulses every 4th cycle with pc_increase=8'h01.
REQ-031 instr 16'hC0FE with Z=1 -> pc_increase=8'hFE (-2); with Z=0 -> pc_increase=8'h01.
REQ-032 exec_busy=1 for 5 cycles in S_DECODE -> instr_valid stays 1 for 6 cycles, pc_enable stays 0, and the instruction takes 9 cycles.
REQ-033 instr 16'hFFFF -> halted=1 and no further pc_enable; Reset then restarts from S_FETCH.
REQ-034 Reset asserted while stalled in S_DECODE -> all outputs are 0 on the next edge, then normal fetch resumes.
REQ-035 Sweep all 16 cond codes against all 32 flag combinations -> branch taken exactly as in the REQ-019 table; cond 4'hF is never taken.
